// File: rtl/mrv32_pkg.sv
// Shared mrv32 definitions: bus widths, strobe constants and
// the owner/state enums used by the memory arbiter.
package mrv32_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int XLEN       = 32;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_t;

  function automatic owner_t other_owner(owner_t o);
    return (o == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
  endfunction

endpackage

// File: rtl/mrv32_req_slot.sv
// One-deep pending request register; a load in the same cycle
// as a clear wins, so an issued slot can be refilled at once.
module mrv32_req_slot #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  output logic                  o_full,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [31:0]           o_wdata,
  output logic [3:0]            o_wstrb
);

  logic                  r_full;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_wstrb <= i_wstrb;
    end else if (i_clear) begin
      r_full  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end
  end

  assign o_full  = r_full;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_wstrb = r_wstrb;

endmodule

// File: rtl/mrv32_mem_arb.sv
// Fetch/LSU arbiter for the shared mrv32 memory bus: buffers one
// request per port, issues one at a time, routes read responses.
module mrv32_mem_arb #(
  parameter int ADDR_WIDTH = mrv32_pkg::ADDR_WIDTH,
  parameter int DATA_PRIO  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_valid,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic [31:0]           f_rdata,
  output logic                  f_rvalid,
  input  logic                  d_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic [31:0]           d_rdata,
  output logic                  d_rvalid,
  output logic                  m_valid,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic [31:0]           m_rdata,
  input  logic                  m_rvalid,
  output logic                  busy,
  output logic                  err
);

  import mrv32_pkg::*;

  localparam logic P_DPRIO = (DATA_PRIO != 0);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  owner_t     r_owner;
  owner_t     r_rr;
  logic       r_err;

  logic                  w_f_full;
  logic [ADDR_WIDTH-1:0] w_f_addr;
  logic [31:0]           w_f_wdata;
  logic [3:0]            w_f_wstrb;
  logic                  w_d_full;
  logic [ADDR_WIDTH-1:0] w_d_addr;
  logic [31:0]           w_d_wdata;
  logic [3:0]            w_d_wstrb;

  logic w_idle;
  logic w_issue;
  logic w_grant_d;
  logic w_iss_f;
  logic w_iss_d;
  logic w_iss_rd;
  logic w_contest;
  logic w_f_load;
  logic w_d_load;
  logic w_ovf;
  logic w_spur;

  assign w_idle    = (r_state == ARB_IDLE);
  assign w_issue   = w_idle & (w_f_full | w_d_full);
  assign w_contest = w_issue & w_f_full & w_d_full;

  // Contested grant goes to data under strict priority or rr=DATA
  assign w_grant_d = w_d_full &
                     (~w_f_full | P_DPRIO | (r_rr == OWN_DATA));

  assign w_iss_d  = w_issue & w_grant_d;
  assign w_iss_f  = w_issue & ~w_grant_d;
  assign w_iss_rd = w_iss_f |
                    (w_iss_d & (w_d_wstrb == WSTRB_NONE));

  assign w_f_load = f_valid & (~w_f_full | w_iss_f);
  assign w_d_load = d_valid & (~w_d_full | w_iss_d);

  assign w_ovf  = (f_valid & w_f_full & ~w_iss_f) |
                  (d_valid & w_d_full & ~w_iss_d);
  assign w_spur = m_rvalid & w_idle;

  mrv32_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_f_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_f_load),
    .i_clear (w_iss_f),
    .i_addr  (f_addr),
    .i_wdata (32'h0),
    .i_wstrb (WSTRB_NONE),
    .o_full  (w_f_full),
    .o_addr  (w_f_addr),
    .o_wdata (w_f_wdata),
    .o_wstrb (w_f_wstrb)
  );

  mrv32_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_d_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_d_load),
    .i_clear (w_iss_d),
    .i_addr  (d_addr),
    .i_wdata (d_wdata),
    .i_wstrb (d_wstrb),
    .o_full  (w_d_full),
    .o_addr  (w_d_addr),
    .o_wdata (w_d_wdata),
    .o_wstrb (w_d_wstrb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_issue && w_iss_rd) begin
          w_state_nxt = ARB_RD_WAIT;
        end
      end
      ARB_RD_WAIT: begin
        if (m_rvalid) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_valid  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    f_rvalid = 1'b0;
    f_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    busy     = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_iss_d) begin
          m_valid = 1'b1;
          m_addr  = w_d_addr;
          m_wdata = w_d_wdata;
          m_wstrb = w_d_wstrb;
        end else if (w_iss_f) begin
          m_valid = 1'b1;
          m_addr  = w_f_addr;
          m_wdata = w_f_wdata;
          m_wstrb = w_f_wstrb;
        end
      end
      ARB_RD_WAIT: begin
        busy = 1'b1;
        if (m_rvalid && r_owner == OWN_FETCH) begin
          f_rvalid = 1'b1;
          f_rdata  = m_rdata;
        end else if (m_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = m_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_FETCH;
    end else if (w_issue && w_iss_rd) begin
      r_owner <= w_iss_d ? OWN_DATA : OWN_FETCH;
    end
  end

  // rr moves only when both ports were competing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= OWN_DATA;
    end else if (w_contest && !P_DPRIO) begin
      r_rr <= other_owner(r_rr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_ovf || w_spur) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: doc/mrv32_mem_arb.md
Name: mrv32_mem_arb

Overview:
- Two-port arbiter that shares the single mrv32 memory bus between the instruction-fetch requester and the LSU data requester.
- The bus is a valid/wstrb/rdata/rvalid bus. A read is a one-cycle valid with wstrb = 0, answered later by rvalid. A write is a one-cycle valid with wstrb != 0 and gets no response.
- Requesters pulse valid for one cycle and have no ready, so the arbiter buffers each request in a one-deep pending slot. It serialises requests to memory with at most one read outstanding and routes each response back to its owner.

Parameters:
- ADDR_WIDTH, mrv32_pkg::ADDR_WIDTH, byte-address width of the memory bus.
- DATA_PRIO, 0, 0 = round-robin between ports; 1 = data port has strict priority.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch read request pulse.
- f_addr  in  ADDR_WIDTH  fetch address.
- f_rdata  out  32  fetch read data.
- f_rvalid  out  1  fetch read response.
- d_valid  in  1  data request pulse.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  32  data write data.
- d_wstrb  in  4  byte strobes; 0 = read.
- d_rdata  out  32  data read data.
- d_rvalid  out  1  data read response.
- m_valid  out  1  memory request.
- m_addr  out  ADDR_WIDTH  memory address.
- m_wdata  out  32  memory write data.
- m_wstrb  out  4  memory strobes.
- m_rdata  in  32  memory read data.
- m_rvalid  in  1  memory read response.
- busy  out  1  a read is outstanding to memory.
- err  out  1  sticky error flag, cleared only by rst.

Behaviour:
- Reset: async on rst high. All pending slots are empty, state = IDLE, rr pointer = DATA, err = 0.
  - All outputs are 0 during reset: m_valid, m_addr, m_wdata, m_wstrb, f_rvalid, d_rvalid, f_rdata, d_rdata, busy.
- Capture: f_valid/d_valid in cycle N load {addr, wdata, wstrb} into that port's pending slot at the end of N.
  - There is no combinational request-to-m_valid path.
- Overflow: a request arriving while the same port's slot is full, and that slot is not being issued this cycle, is dropped and sets err.
  - A slot issued in cycle N may be refilled in cycle N.
- FSM states: IDLE, RD_WAIT.
  - IDLE: if any slot is pending, drive m_valid = 1 with the granted slot's fields and clear that slot.
    - Granted read: record owner; next state = RD_WAIT.
    - Granted write: stay in IDLE.
    - At most one issue per cycle.
  - RD_WAIT: m_valid = 0; busy = 1.
    - On m_rvalid, next state = IDLE; the next issue is no earlier than the following cycle.
- Arbitration, when both slots are pending in IDLE:
  - DATA_PRIO = 0: the port named by the rr pointer wins, and the pointer then flips to the other port.
  - DATA_PRIO = 1: data always wins.
  - A single pending slot always wins; the rr pointer updates only on contested grants.
- Response routing is combinational in the m_rvalid cycle while in RD_WAIT:
  - Owner FETCH: f_rvalid = 1, f_rdata = m_rdata.
  - Owner DATA: d_rvalid = 1, d_rdata = m_rdata.
  - The non-owner's rvalid = 0 and rdata = 0.
- Spurious response: m_rvalid while in IDLE is ignored (no rvalid to either port) and sets err.
- Latency (idle bus, memory with 1-cycle read latency):
  - Request in N → m_valid in N+1 → m_rvalid and the requester's rvalid in N+2.
  - Write: m_valid in N+1.
- m_addr, m_wdata and m_wstrb are 0 whenever m_valid = 0.
- Fetch issues always carry m_wstrb = 0 and m_wdata = 0.
- Reset mid-read: the outstanding read is abandoned. An m_rvalid arriving after reset is treated as spurious and sets err.

Decomposition:
- mrv32_pkg holds the shared definitions:
  - owner_t enum {OWN_FETCH, OWN_DATA};
  - arb_state_t enum {ARB_IDLE, ARB_RD_WAIT};
  - WSTRB_NONE, reused from the existing package.
- One sub-module, mrv32_req_slot: a one-deep pending register with a load/clear/full interface, instantiated once per port (fetch instance with wstrb tied 0).

Test Plan:
1. Fetch read: f_valid at cycle 1, f_addr = 0x100; memory returns 0xDEADBEEF one cycle after m_valid → m_valid at cycle 2 with m_addr = 0x100, m_wstrb = 0; f_rvalid = 1 and f_rdata = 0xDEADBEEF at cycle 3; d_rvalid stays 0.
2. Contention, DATA_PRIO = 0, after reset: f_valid and d_valid (read, 0x200) in the same cycle → data is issued first. The fetch is issued the cycle after the data rvalid. A second simultaneous pair is then granted to fetch first.
3. Write during an outstanding read: fetch read outstanding, d_valid with d_wstrb = 4'b0011, d_wdata = 0x0000ABCD → the write is held. It issues (m_valid, m_wstrb = 0011) in the cycle after m_rvalid; busy = 0 during the write.
4. Overflow: fetch read outstanding, d_valid (read), then a second d_valid two cycles later → the second request is dropped, err = 1 and stays 1. The first data read completes normally.
5. Spurious response: m_rvalid pulsed in IDLE with m_rdata = 0x12345678 → f_rvalid = d_rvalid = 0; err = 1 on the next cycle.
6. Reset mid-read: rst asserted in RD_WAIT → all outputs 0 asynchronously. After rst is released, m_rvalid → no rvalid to either port, err = 1; a new f_valid issues normally.
